// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage: 4-entry register file, pending scoreboard, one-cycle ALU issue
// Optional build macro: DECODE_BYPASS_EN (same-cycle writeback forwarding into hazard check and operands)

module decode_issue #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [3:0]        opcode,
  output logic              alu_valid,
  output logic [1:0]        alu_rd,
  input  logic              wb_en,
  input  logic [1:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  // Architectural state and issue registers
  logic [DATA_W-1:0] regfile_q [4];
  logic [DATA_W-1:0] regfile_d [4];
  logic [3:0]        pending_q;
  logic [3:0]        pending_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [1:0]        alu_rd_q, alu_rd_d;
  logic              alu_valid_q, alu_valid_d;

  // Decoded instruction fields
  logic [1:0]        op_f;
  logic [1:0]        rd_f;
  logic [1:0]        rs1_f;
  logic [1:0]        rs2_f;
  logic [3:0]        op_onehot;

  // Hazard / operand selection
  logic [3:0]        busy;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic              accept;

  // Split the instruction word and map the 2-bit op to a one-hot ALU opcode
  always_comb begin
    op_f  = instr[7:6];
    rd_f  = instr[5:4];
    rs1_f = instr[3:2];
    rs2_f = instr[1:0];
    op_onehot = 4'b0000;
    case (op_f)
      2'b00:   op_onehot = 4'b0001;
      2'b01:   op_onehot = 4'b0010;
      2'b10:   op_onehot = 4'b0100;
      default: op_onehot = 4'b1000;
    endcase
  end

  // Per-register busy view used by the stall check; with forwarding a writeback
  // landing this cycle releases its register immediately
  always_comb begin
    busy = pending_q;
`ifdef DECODE_BYPASS_EN
    if (wb_en) begin
      busy[wb_addr] = 1'b0;
    end
`endif
  end

  // Ready when no source or destination of the presented instruction is outstanding
  always_comb begin
    instr_ready = ~(busy[rd_f] | busy[rs1_f] | busy[rs2_f]);
    accept      = instr_valid & instr_ready;
  end

  // Operand read; the forwarding mux only exists in the bypass build
  always_comb begin
    rs1_val = regfile_q[rs1_f];
    rs2_val = regfile_q[rs2_f];
`ifdef DECODE_BYPASS_EN
    if (wb_en && (wb_addr == rs1_f)) begin
      rs1_val = wb_data;
    end
    if (wb_en && (wb_addr == rs2_f)) begin
      rs2_val = wb_data;
    end
`endif
  end

  // Register file and scoreboard update: writeback clears first, a new issue
  // to the same register then re-marks it outstanding
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      regfile_d[i] = regfile_q[i];
    end
    pending_d = pending_q;
    if (wb_en) begin
      regfile_d[wb_addr] = wb_data;
      pending_d[wb_addr] = 1'b0;
    end
    if (accept) begin
      pending_d[rd_f] = 1'b1;
    end
  end

  // Issue register: capture operands on accept, otherwise emit a bubble while
  // operands and tag keep their last values
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    alu_rd_d    = alu_rd_q;
    opcode_d    = 4'b0000;
    alu_valid_d = 1'b0;
    if (accept) begin
      a_d         = rs1_val;
      b_d         = rs2_val;
      alu_rd_d    = rd_f;
      opcode_d    = op_onehot;
      alu_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regfile_q[i] <= '0;
      end
      pending_q   <= 4'b0000;
      a_q         <= '0;
      b_q         <= '0;
      opcode_q    <= 4'b0000;
      alu_rd_q    <= 2'b00;
      alu_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        regfile_q[i] <= regfile_d[i];
      end
      pending_q   <= pending_d;
      a_q         <= a_d;
      b_q         <= b_d;
      opcode_q    <= opcode_d;
      alu_rd_q    <= alu_rd_d;
      alu_valid_q <= alu_valid_d;
    end
  end

  // Output drive
  always_comb begin
    A         = a_q;
    B         = b_q;
    opcode    = opcode_q;
    alu_rd    = alu_rd_q;
    alu_valid = alu_valid_q;
  end

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - randomized and directed bench for decode_issue against a behavioural model

module tb_decode_issue;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] a_o;
  logic [7:0] b_o;
  logic [3:0] opcode;
  logic       alu_valid;
  logic [1:0] alu_rd;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;

  decode_issue #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .A           (a_o),
    .B           (b_o),
    .opcode      (opcode),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural registers, outstanding flags, expected outputs
  int   m_reg  [4];
  bit   m_pend [4];
  int   e_a, e_b, e_op, e_rd, e_v;
  bit   bypass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_reg[i]  = 0;
      m_pend[i] = 0;
    end
    e_a = 0; e_b = 0; e_op = 0; e_rd = 0; e_v = 0;
  endtask

  function automatic bit m_blocked(int r, bit we, int wa);
    return m_pend[r] && !(bypass && we && wa == r);
  endfunction

  function automatic int m_read(int r, bit we, int wa, int wd);
    if (bypass && we && wa == r) return wd;
    return m_reg[r];
  endfunction

  function automatic bit m_ready(int ins, bit we, int wa);
    int rd, rs1, rs2;
    rd  = (ins / 16) % 4;
    rs1 = (ins / 4) % 4;
    rs2 = ins % 4;
    return !(m_blocked(rd, we, wa) || m_blocked(rs1, we, wa) || m_blocked(rs2, we, wa));
  endfunction

  task automatic check_outputs();
    check("alu_valid", alu_valid, e_v);
    check("opcode", opcode, e_op);
    check("A", a_o, e_a);
    check("B", b_o, e_b);
    check("alu_rd", alu_rd, e_rd);
  endtask

  // One cycle: apply inputs just after an edge, check ready, clock, update model, check outputs
  task automatic step(input bit v, input int ins, input bit we, input int wa, input int wd);
    bit rdy, acc;
    int rd, rs1, rs2;
    instr_valid = v;
    instr       = 8'(ins);
    wb_en       = we;
    wb_addr     = 2'(wa);
    wb_data     = 8'(wd);
    #1;
    rdy = m_ready(ins, we, wa);
    check("instr_ready", instr_ready, rdy);
    acc = v && rdy;
    rd  = (ins / 16) % 4;
    rs1 = (ins / 4) % 4;
    rs2 = ins % 4;
    @(posedge clk);
    if (acc) begin
      e_a  = m_read(rs1, we, wa, wd);
      e_b  = m_read(rs2, we, wa, wd);
      e_op = 1 << (ins / 64);
      e_rd = rd;
      e_v  = 1;
    end else begin
      e_op = 0;
      e_v  = 0;
    end
    if (we) begin
      m_reg[wa]  = wd;
      m_pend[wa] = 0;
    end
    if (acc) m_pend[rd] = 1;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0; wb_en = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  int ins, wa, wd, r;
  bit v, we;

  initial begin
`ifdef DECODE_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    rst_n = 1'b0; instr = 8'h00; instr_valid = 1'b0;
    wb_en = 1'b0; wb_addr = 2'd0; wb_data = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // ADD r1 = r0 + r0 from reset
    step(1, 8'b00_01_00_00, 0, 0, 0);
    check("add_opcode", opcode, 4'b0001);
    check("add_rd", alu_rd, 1);
    // r1 now outstanding: an instruction reading r1 must stall, one avoiding r1 must not
    step(0, 8'b00_00_01_00, 0, 0, 0);
    step(0, 8'b00_00_10_11, 0, 0, 0);
    check("idle_opcode", opcode, 4'b0000);
    step(0, 0, 1, 1, 8'h00);

    // Preload r2/r3 then XOR r0 = r2 ^ r3
    step(0, 0, 1, 2, 8'h0F);
    step(0, 0, 1, 3, 8'hF0);
    step(1, 8'b11_00_10_11, 0, 0, 0);
    check("xor_A", a_o, 8'h0F);
    check("xor_B", b_o, 8'hF0);
    check("xor_opcode", opcode, 4'b1000);
    // Idle after issue: bubble with held operands
    step(0, 0, 0, 0, 0);
    check("bubble_A", a_o, 8'h0F);
    check("bubble_B", b_o, 8'hF0);
    step(0, 0, 1, 0, 8'h11);

    // RAW: ADD r1 = r2 + r3, then AND r0 = r1 & r2 waits for r1 writeback
    step(1, 8'b00_01_10_11, 0, 0, 0);
    step(1, 8'b10_00_01_10, 0, 0, 0);
    check("raw_stall_valid", alu_valid, 0);
    step(1, 8'b10_00_01_10, 0, 0, 0);
    step(1, 8'b10_00_01_10, 1, 1, 8'h55);
    if (bypass) check("raw_bypass_A", a_o, 8'h55);
    else        check("raw_wait_valid", alu_valid, 0);
    if (!bypass) begin
      step(1, 8'b10_00_01_10, 0, 0, 0);
      check("raw_late_A", a_o, 8'h55);
    end
    step(0, 0, 1, 0, 8'h22);

    // WAW: two writes to r2 back-to-back
    step(1, 8'b01_10_00_00, 0, 0, 0);
    step(1, 8'b01_10_00_00, 0, 0, 0);
    check("waw_stall_valid", alu_valid, 0);
    step(1, 8'b01_10_00_00, 1, 2, 8'h33);
    step(0, 0, 1, 2, 8'h44);

    // Reset in the middle of a stall with r1 outstanding
    step(1, 8'b00_01_00_00, 0, 0, 0);
    step(1, 8'b00_00_01_00, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", alu_valid, 0);
    check("rst_async_A", a_o, 0);
    do_reset();
    step(1, 8'b00_00_01_00, 0, 0, 0);
    check("post_rst_A", a_o, 0);

    // Randomized traffic; writebacks mostly target outstanding registers so stalls drain
    for (int n = 0; n < 400; n++) begin
      ins = int'($urandom_range(0, 255));
      v   = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 1) != 0);
      wa  = int'($urandom_range(0, 3));
      wd  = int'($urandom_range(0, 255));
      r   = int'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        if (m_pend[(r + k) % 4]) begin
          wa = (r + k) % 4;
          break;
        end
      end
      step(v, ins, we, wa, wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter: DATA_W, 8, operand/register width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: instr  input  8  instruction: [7:6] op (00 ADD, 01 OR, 10 AND, 11 XOR), [5:4] rd, [3:2] rs1, [1:0] rs2.
REQ-005 SHALL have port: instr_valid  input  1  instr is presented.
REQ-006 SHALL have port: instr_ready  output  1  decode can accept instr this cycle.
REQ-007 SHALL have port: A  output  DATA_W  operand 1 to ALU (value of rs1).
REQ-008 SHALL have port: B  output  DATA_W  operand 2 to ALU (value of rs2).
REQ-009 SHALL have port: opcode  output  4  one-hot ALU opcode (ADD 0001, OR 0010, AND 0100, XOR 1000).
REQ-010 SHALL have port: alu_valid  output  1  A/B/opcode/alu_rd carry an issued instruction this cycle.
REQ-011 SHALL have port: alu_rd  output  2  destination register tag travelling with the issue.
REQ-012 SHALL have port: wb_en, wb_addr, wb_data  input  1/2/DATA_W  writeback of ALU result into the register file.

Function
REQ-013 SHALL contain a 4-entry x DATA_W register file and a 4-bit pending scoreboard.
REQ-014 SHALL assert instr_ready combinationally when none of pending[rs1], pending[rs2], pending[rd] is set for the current instr.
REQ-015 SHALL accept an instruction only in a cycle where instr_valid and instr_ready are both high.
REQ-016 SHALL register A, B, opcode, alu_rd and alu_valid=1 on the clock edge that accepts; latency accept-to-alu_valid is exactly 1 cycle.
REQ-017 SHALL, in every cycle without an accept, drive alu_valid=0 and opcode=4'b0000 on the next edge, with A, B and alu_rd holding their previous values.
REQ-018 SHALL set pending[rd] on the accepting edge.
REQ-019 SHALL, on wb_en, write wb_data to regfile[wb_addr] and clear pending[wb_addr] on the same edge.
REQ-020 SHALL treat wb_en to a non-pending register as a plain write; the scoreboard is unchanged.
REQ-021 SHALL, without bypass, read operands from the register file as it stood before the edge; a writeback in the same cycle is visible to stall logic and operands only from the next cycle.
REQ-022 SHALL sustain one issue per cycle for back-to-back independent instructions.
REQ-023 SHALL hold instr_ready low while an instruction whose rd equals the rd, rs1 or rs2 of the waiting instruction is outstanding (WAW and RAW both stall).

Reset
REQ-024 SHALL, while rst_n is low, force regfile=0, pending=0, A=0, B=0, alu_rd=0, opcode=4'b0000 and alu_valid=0, independent of clk.
REQ-025 SHALL discard any in-flight issue on reset; the first accept after release sees all registers zero and not pending.

Configuration
REQ-026 SHALL implement DECODE_BYPASS_EN: when defined, a same-cycle writeback whose wb_addr matches rs1/rs2/rd clears that register's hazard for the current instr_ready evaluation, and wb_data is forwarded into A/B on the accepting edge.
REQ-027 SHALL, when DECODE_BYPASS_EN is not defined, contain no forwarding path; behaviour is exactly REQ-021.

Verification
REQ-028 SHALL cover: reset, then instr=8'b00_01_00_00 (ADD r1=r0+r0) valid -> next cycle alu_valid=1, opcode=0001, A=0, B=0, alu_rd=1, pending=0010.
REQ-029 SHALL cover: preload r2=8'h0F, r3=8'hF0 via wb_en, issue XOR r0=r2^r3 -> A=8'h0F, B=8'hF0, opcode=1000, alu_rd=0.
REQ-030 SHALL cover: issue ADD r1=r2+r3 then AND r0=r1&r2 next cycle -> instr_ready=0 until wb_en with wb_addr=1; no bypass: issue one cycle after the writeback; DECODE_BYPASS_EN: issue in the writeback cycle with A=wb_data.
REQ-031 SHALL cover: issue to rd=2 twice back-to-back -> second stalls (WAW) until writeback to r2.
REQ-032 SHALL cover: rst_n low mid-stall with pending=0010 -> all outputs 0, instr_ready=1 after release.
REQ-033 SHALL cover: idle cycle after an issue -> alu_valid=0, opcode=0000, A/B unchanged.
